// File: rtl/mem_wb_writeback_if.sv
// MEM-to-WB boundary bundle: MEM-stage payload, pipeline control, ID read ports and WB forwarding outputs.
interface mem_wb_writeback_if #(
  parameter int unsigned XLEN = 32
);
  logic            stall;
  logic            flush;
  logic            validin;
  logic            wregin;
  logic            m2regin;
  logic [4:0]      RdRtin;
  logic [XLEN-1:0] aluresultin;
  logic [XLEN-1:0] datain;
  logic [4:0]      rna;
  logic [4:0]      rnb;
  logic [XLEN-1:0] qa;
  logic [XLEN-1:0] qb;
  logic            wb_wreg;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic [31:0]     instret;

  modport master (
    output stall, flush, validin, wregin, m2regin, RdRtin, aluresultin, datain, rna, rnb,
    input  qa, qb, wb_wreg, wb_rd, wb_data, instret
  );

  modport slave (
    input  stall, flush, validin, wregin, m2regin, RdRtin, aluresultin, datain, rna, rnb,
    output qa, qb, wb_wreg, wb_rd, wb_data, instret
  );
endinterface

// File: rtl/mem_wb_writeback.sv
// MEM/WB pipeline register, writeback select, bypassed 2R1W register file and retired-instruction counter.
module mem_wb_writeback #(
  parameter int unsigned NREG = 32,
  parameter int unsigned XLEN = 32
) (
  input  logic               clk,
  input  logic               clrn,
  mem_wb_writeback_if.slave  bus
);

  localparam int unsigned RW = 5;
  localparam int unsigned CW = 32;

  typedef struct packed {
    logic            valid;
    logic            wreg;
    logic            m2reg;
    logic [RW-1:0]   rd;
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] mem;
  } mem_wb_t;

  mem_wb_t         wb_q;
  logic [XLEN-1:0] regs [NREG];
  logic [CW-1:0]   instret_q;

  logic            wb_wreg_c;
  logic [XLEN-1:0] wb_data_c;

  // MEM/WB capture: flush inserts a bubble and wins over stall
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wb_q <= '0;
    end else if (bus.flush) begin
      wb_q.valid <= 1'b0;
      wb_q.wreg  <= 1'b0;
    end else if (!bus.stall) begin
      wb_q.valid <= bus.validin;
      wb_q.wreg  <= bus.wregin;
      wb_q.m2reg <= bus.m2regin;
      wb_q.rd    <= bus.RdRtin;
      wb_q.alu   <= bus.aluresultin;
      wb_q.mem   <= bus.datain;
    end
  end

  always_comb begin
    wb_wreg_c = wb_q.wreg & wb_q.valid;
    wb_data_c = wb_q.m2reg ? wb_q.mem : wb_q.alu;
  end

  // Commit ignores stall so a held instruction keeps rewriting the same value
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < int'(NREG); i++) begin
        regs[i] <= '0;
      end
    end else if (wb_wreg_c && (wb_q.rd != RW'(0))) begin
      regs[wb_q.rd] <= wb_data_c;
    end
  end

  // An instruction retires when it leaves WB
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      instret_q <= '0;
    end else if (wb_q.valid && !bus.flush && !bus.stall) begin
      instret_q <= instret_q + CW'(1);
    end
  end

  // Read ports forward the in-flight WB value ahead of the array
  always_comb begin
    bus.qa = regs[bus.rna];
    bus.qb = regs[bus.rnb];
    if (wb_wreg_c && (wb_q.rd == bus.rna)) bus.qa = wb_data_c;
    if (wb_wreg_c && (wb_q.rd == bus.rnb)) bus.qb = wb_data_c;
    if (bus.rna == RW'(0)) bus.qa = '0;
    if (bus.rnb == RW'(0)) bus.qb = '0;
  end

  assign bus.wb_wreg = wb_wreg_c;
  assign bus.wb_rd   = wb_q.rd;
  assign bus.wb_data = wb_data_c;
  assign bus.instret = instret_q;

endmodule

// File: tb/tb_mem_wb_writeback.sv
// Directed bench for mem_wb_writeback: one task per scenario with hand-computed expectations.
module tb_mem_wb_writeback;

  logic clk;
  logic clrn;
  int   pass_cnt;
  int   total;

  mem_wb_writeback_if #(.XLEN(32)) bus ();

  mem_wb_writeback #(.NREG(32), .XLEN(32)) dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bubble();
    bus.stall       = 1'b0;
    bus.flush       = 1'b0;
    bus.validin     = 1'b0;
    bus.wregin      = 1'b0;
    bus.m2regin     = 1'b0;
    bus.RdRtin      = 5'd0;
    bus.aluresultin = 32'h0;
    bus.datain      = 32'h0;
  endtask

  task automatic drive_instr(input logic m2, input logic [4:0] rd,
                             input logic [31:0] alu, input logic [31:0] mem);
    bus.validin     = 1'b1;
    bus.wregin      = 1'b1;
    bus.m2regin     = m2;
    bus.RdRtin      = rd;
    bus.aluresultin = alu;
    bus.datain      = mem;
  endtask

  task automatic test_reset();
    int bad;
    clrn            = 1'b0;
    bus.stall       = 1'($urandom);
    bus.flush       = 1'($urandom);
    bus.validin     = 1'b1;
    bus.wregin      = 1'b1;
    bus.m2regin     = 1'($urandom);
    bus.RdRtin      = 5'($urandom);
    bus.aluresultin = $urandom;
    bus.datain      = $urandom;
    bus.rna         = 5'd0;
    bus.rnb         = 5'd0;
    step();
    step();
    total++;
    if (bus.wb_wreg !== 1'b0) $display("FAIL reset_wb_wreg: got %b want 0", bus.wb_wreg);
    else pass_cnt++;
    total++;
    if (bus.wb_rd !== 5'd0) $display("FAIL reset_wb_rd: got %0d want 0", bus.wb_rd);
    else pass_cnt++;
    total++;
    if (bus.wb_data !== 32'h0) $display("FAIL reset_wb_data: got %h want 00000000", bus.wb_data);
    else pass_cnt++;
    total++;
    if (bus.instret !== 32'h0) $display("FAIL reset_instret: got %0d want 0", bus.instret);
    else pass_cnt++;
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      bus.rna = 5'(i);
      bus.rnb = 5'(31 - i);
      #1;
      if (bus.qa !== 32'h0 || bus.qb !== 32'h0) bad++;
    end
    total++;
    if (bad != 0) $display("FAIL reset_read_ports: got %0d nonzero reads want 0", bad);
    else pass_cnt++;
    drive_bubble();
    clrn = 1'b1;
    step();
  endtask

  task automatic test_alu_writeback();
    drive_instr(1'b0, 5'd5, 32'h0000_1234, 32'h0000_0077);
    bus.rna = 5'd5;
    step();
    drive_bubble();
    #1;
    total++;
    if (bus.wb_rd !== 5'd5) $display("FAIL alu_wb_rd: got %0d want 5", bus.wb_rd);
    else pass_cnt++;
    total++;
    if (bus.wb_wreg !== 1'b1) $display("FAIL alu_wb_wreg: got %b want 1", bus.wb_wreg);
    else pass_cnt++;
    total++;
    if (bus.wb_data !== 32'h0000_1234) $display("FAIL alu_wb_data: got %h want 00001234", bus.wb_data);
    else pass_cnt++;
    total++;
    if (bus.qa !== 32'h0000_1234) $display("FAIL alu_bypass_qa: got %h want 00001234", bus.qa);
    else pass_cnt++;
    step();
    total++;
    if (bus.qa !== 32'h0000_1234) $display("FAIL alu_commit_qa: got %h want 00001234", bus.qa);
    else pass_cnt++;
    total++;
    if (bus.instret !== 32'd1) $display("FAIL alu_instret: got %0d want 1", bus.instret);
    else pass_cnt++;
  endtask

  task automatic test_load_writeback();
    drive_instr(1'b1, 5'd9, 32'h0000_0040, 32'hDEAD_BEEF);
    bus.rnb = 5'd9;
    step();
    drive_bubble();
    #1;
    total++;
    if (bus.wb_data !== 32'hDEAD_BEEF) $display("FAIL load_wb_data: got %h want deadbeef", bus.wb_data);
    else pass_cnt++;
    total++;
    if (bus.qb !== 32'hDEAD_BEEF) $display("FAIL load_bypass_qb: got %h want deadbeef", bus.qb);
    else pass_cnt++;
    step();
    total++;
    if (bus.qb !== 32'hDEAD_BEEF) $display("FAIL load_commit_qb: got %h want deadbeef", bus.qb);
    else pass_cnt++;
    total++;
    if (bus.qa !== 32'h0000_1234) $display("FAIL load_keeps_r5: got %h want 00001234", bus.qa);
    else pass_cnt++;
    total++;
    if (bus.instret !== 32'd2) $display("FAIL load_instret: got %0d want 2", bus.instret);
    else pass_cnt++;
  endtask

  task automatic test_reg_zero();
    drive_instr(1'b0, 5'd0, 32'hFFFF_FFFF, 32'h0);
    bus.rna = 5'd0;
    step();
    drive_bubble();
    #1;
    total++;
    if (bus.wb_wreg !== 1'b1) $display("FAIL zero_wb_wreg: got %b want 1", bus.wb_wreg);
    else pass_cnt++;
    total++;
    if (bus.qa !== 32'h0) $display("FAIL zero_bypass_qa: got %h want 00000000", bus.qa);
    else pass_cnt++;
    step();
    total++;
    if (bus.qa !== 32'h0) $display("FAIL zero_commit_qa: got %h want 00000000", bus.qa);
    else pass_cnt++;
    total++;
    if (bus.instret !== 32'd3) $display("FAIL zero_instret: got %0d want 3", bus.instret);
    else pass_cnt++;
  endtask

  task automatic test_stall_flush();
    drive_instr(1'b0, 5'd12, 32'hA5A5_0001, 32'h0);
    step();
    drive_instr(1'b1, 5'd13, 32'h1111_1111, 32'h2222_2222);
    bus.stall = 1'b1;
    bus.rnb   = 5'd12;
    for (int c = 0; c < 3; c++) begin
      step();
      total++;
      if (bus.wb_rd !== 5'd12 || bus.wb_data !== 32'hA5A5_0001 || bus.wb_wreg !== 1'b1)
        $display("FAIL stall_hold_%0d: got rd=%0d data=%h wreg=%b want rd=12 data=a5a50001 wreg=1",
                 c, bus.wb_rd, bus.wb_data, bus.wb_wreg);
      else pass_cnt++;
      total++;
      if (bus.instret !== 32'd3) $display("FAIL stall_instret_%0d: got %0d want 3", c, bus.instret);
      else pass_cnt++;
    end
    bus.flush = 1'b1;
    bus.rna   = 5'd12;
    step();
    total++;
    if (bus.wb_wreg !== 1'b0) $display("FAIL flush_wb_wreg: got %b want 0", bus.wb_wreg);
    else pass_cnt++;
    total++;
    if (bus.instret !== 32'd3) $display("FAIL flush_instret: got %0d want 3", bus.instret);
    else pass_cnt++;
    total++;
    if (bus.qa !== 32'hA5A5_0001) $display("FAIL flush_regfile_r12: got %h want a5a50001", bus.qa);
    else pass_cnt++;
    drive_bubble();
    step();
    total++;
    if (bus.instret !== 32'd3) $display("FAIL post_flush_instret: got %0d want 3", bus.instret);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    drive_instr(1'b0, 5'd5, 32'h0000_2222, 32'h0);
    bus.rna = 5'd5;
    bus.rnb = 5'd6;
    step();
    drive_instr(1'b0, 5'd6, 32'h0000_3333, 32'h0);
    #1;
    total++;
    if (bus.qa !== 32'h0000_2222) $display("FAIL b2b_bypass_over_old: got %h want 00002222", bus.qa);
    else pass_cnt++;
    step();
    drive_bubble();
    #1;
    total++;
    if (bus.qa !== 32'h0000_2222) $display("FAIL b2b_commit_r5: got %h want 00002222", bus.qa);
    else pass_cnt++;
    total++;
    if (bus.qb !== 32'h0000_3333) $display("FAIL b2b_bypass_r6: got %h want 00003333", bus.qb);
    else pass_cnt++;
    step();
    total++;
    if (bus.instret !== 32'd5) $display("FAIL b2b_instret: got %0d want 5", bus.instret);
    else pass_cnt++;
  endtask

  task automatic test_mid_reset();
    drive_instr(1'b0, 5'd7, 32'h0000_0055, 32'h0);
    bus.rna = 5'd7;
    step();
    drive_bubble();
    step();
    total++;
    if (bus.qa !== 32'h0000_0055 || bus.instret !== 32'd6)
      $display("FAIL midreset_pre: got qa=%h instret=%0d want qa=00000055 instret=6", bus.qa, bus.instret);
    else pass_cnt++;
    #2;
    clrn = 1'b0;
    #1;
    total++;
    if (bus.qa !== 32'h0) $display("FAIL midreset_async_qa: got %h want 00000000", bus.qa);
    else pass_cnt++;
    total++;
    if (bus.instret !== 32'h0) $display("FAIL midreset_instret: got %0d want 0", bus.instret);
    else pass_cnt++;
    clrn = 1'b1;
    step();
    total++;
    if (bus.qa !== 32'h0 || bus.wb_wreg !== 1'b0)
      $display("FAIL midreset_after: got qa=%h wreg=%b want qa=00000000 wreg=0", bus.qa, bus.wb_wreg);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt = 0;
    total    = 0;
    test_reset();
    test_alu_writeback();
    test_load_writeback();
    test_reg_zero();
    test_stall_flush();
    test_back_to_back();
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
